// File: rtl/membus_arbiter_if.sv
// MemoryBus command/result types and the bundled arbiter bus.
// The "master" modport is the arbiter's view: it drives done/err/result back
// to both masters and drives the latched command toward the slave.
package MemoryBus;

  typedef struct packed {
    logic        mem_read;
    logic        mem_write;
    logic [29:0] addr;
    logic [3:0]  mask_byte;
    logic [31:0] write_data;
  } Cmd;

  typedef struct packed {
    logic [31:0] read_data;
  } Result;

endpackage

interface membus_arbiter_if;

  MemoryBus::Cmd    a_cmd;
  logic             a_done;
  logic             a_err;
  MemoryBus::Result a_result;

  MemoryBus::Cmd    b_cmd;
  logic             b_done;
  logic             b_err;
  MemoryBus::Result b_result;

  MemoryBus::Cmd    slave_cmd;
  logic             slave_ack;
  MemoryBus::Result slave_result;

  logic [1:0]       grant;

  modport master (
    input  a_cmd, b_cmd, slave_ack, slave_result,
    output a_done, a_err, a_result, b_done, b_err, b_result, slave_cmd, grant
  );

  modport slave (
    output a_cmd, b_cmd, slave_ack, slave_result,
    input  a_done, a_err, a_result, b_done, b_err, b_result, slave_cmd, grant
  );

endinterface

// File: rtl/membus_arbiter.sv
// Two-master MemoryBus arbiter: registered grant, command latching,
// fixed A priority with an anti-starvation quota for B, and a slave-ack timeout.
module membus_arbiter #(
  parameter int A_MAX_CONSEC = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic               clk,
  input  logic               rst,
  membus_arbiter_if.master   bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_A = 2'd1;
  localparam logic [1:0] BUSY_B = 2'd2;

  localparam int FW = $clog2(A_MAX_CONSEC + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [FW-1:0] FAIR_MAX = FW'(A_MAX_CONSEC);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  logic [1:0]    state;
  MemoryBus::Cmd cmd_q;
  logic [FW-1:0] fair_cnt;
  logic [TW-1:0] to_cnt;

  logic a_req;
  logic b_req;
  logic a_wins;
  logic b_wins;
  logic busy;
  logic expire;
  logic finish;

  // A has priority until it has used up its quota of back-to-back wins over a waiting B.
  assign a_req  = bus.a_cmd.mem_read | bus.a_cmd.mem_write;
  assign b_req  = bus.b_cmd.mem_read | bus.b_cmd.mem_write;
  assign a_wins = a_req & (~b_req | (fair_cnt != FAIR_MAX));
  assign b_wins = b_req & ~a_wins;

  // An ack on the last allowed cycle wins over the timeout, so expire requires no ack.
  assign busy   = (state == BUSY_A) || (state == BUSY_B);
  assign expire = busy & ~bus.slave_ack & (to_cnt == TO_LAST);
  assign finish = (busy & bus.slave_ack) | expire;

  // Arbitration, command latching, fairness and timeout bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cmd_q    <= '0;
      fair_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (a_wins) begin
            state  <= BUSY_A;
            cmd_q  <= bus.a_cmd;
            to_cnt <= '0;
            if (!b_req)
              fair_cnt <= '0;
            else if (fair_cnt != FAIR_MAX)
              fair_cnt <= fair_cnt + FW'(1);
          end else if (b_wins) begin
            state    <= BUSY_B;
            cmd_q    <= bus.b_cmd;
            to_cnt   <= '0;
            fair_cnt <= '0;
          end
        end
        BUSY_A, BUSY_B: begin
          if (finish)
            state <= IDLE;
          else
            to_cnt <= to_cnt + TW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Grant and slave command come straight from registers; only ack/result reach done/result.
  assign bus.grant     = {state == BUSY_B, state == BUSY_A};
  assign bus.slave_cmd = busy ? cmd_q : '0;

  assign bus.a_done   = (state == BUSY_A) & finish;
  assign bus.a_err    = (state == BUSY_A) & expire;
  assign bus.a_result = ((state == BUSY_A) && bus.slave_ack) ? bus.slave_result : '0;

  assign bus.b_done   = (state == BUSY_B) & finish;
  assign bus.b_err    = (state == BUSY_B) & expire;
  assign bus.b_result = ((state == BUSY_B) && bus.slave_ack) ? bus.slave_result : '0;

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed self-checking bench for membus_arbiter (A_MAX_CONSEC=4, TIMEOUT=16).
// Inputs change and outputs are sampled just after the falling clock edge.
module tb_membus_arbiter;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  membus_arbiter_if bus ();

  membus_arbiter #(.A_MAX_CONSEC(4), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic MemoryBus::Cmd mk(input logic rd, input logic wr, input logic [29:0] addr,
                                       input logic [3:0] mask, input logic [31:0] data);
    MemoryBus::Cmd c;
    c.mem_read   = rd;
    c.mem_write  = wr;
    c.addr       = addr;
    c.mask_byte  = mask;
    c.write_data = data;
    return c;
  endfunction

  task automatic check_output(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  logic [1:0]    exp_grant [10];
  logic [2:0]    exp_fair  [10];
  MemoryBus::Cmd wr_cmd;

  // Linear directed test sequence.
  initial begin
    compared   = 0;
    mismatched = 0;
    exp_grant  = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    exp_fair   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

    rst              = 1'b0;
    bus.a_cmd        = '0;
    bus.b_cmd        = '0;
    bus.slave_ack    = 1'b0;
    bus.slave_result = '0;

    // Reset state
    next_cycle();
    next_cycle();
    check_output("rst_grant", 72'(bus.grant), 72'(2'b00));
    check_output("rst_slave_cmd", 72'(bus.slave_cmd), 72'(0));
    check_output("rst_a_done", 72'(bus.a_done), 72'(0));
    check_output("rst_b_done", 72'(bus.b_done), 72'(0));
    check_output("rst_a_err", 72'(bus.a_err), 72'(0));
    check_output("rst_b_err", 72'(bus.b_err), 72'(0));
    check_output("rst_fair", 72'(dut.fair_cnt), 72'(0));
    rst = 1'b1;

    // Lone B read, zero-wait slave
    next_cycle();
    bus.b_cmd = mk(1'b1, 1'b0, 30'h10, 4'hF, 32'h0);
    next_cycle();
    check_output("t1_grant", 72'(bus.grant), 72'(2'b10));
    check_output("t1_slave_cmd", 72'(bus.slave_cmd), 72'(mk(1'b1, 1'b0, 30'h10, 4'hF, 32'h0)));
    bus.slave_ack    = 1'b1;
    bus.slave_result = 32'hCAFE_F00D;
    #1;
    check_output("t1_b_done", 72'(bus.b_done), 72'(1));
    check_output("t1_b_err", 72'(bus.b_err), 72'(0));
    check_output("t1_b_result", 72'(bus.b_result), 72'(32'hCAFE_F00D));
    check_output("t1_a_done", 72'(bus.a_done), 72'(0));
    check_output("t1_a_result", 72'(bus.a_result), 72'(0));
    bus.b_cmd = '0;
    next_cycle();
    bus.slave_ack = 1'b0;
    #1;
    check_output("t1_idle_grant", 72'(bus.grant), 72'(2'b00));
    check_output("t1_idle_b_done", 72'(bus.b_done), 72'(0));

    // Both masters continuously requesting, zero-wait slave
    bus.a_cmd        = mk(1'b1, 1'b0, 30'h1, 4'hF, 32'h0);
    bus.b_cmd        = mk(1'b1, 1'b0, 30'h2, 4'hF, 32'h0);
    bus.slave_ack    = 1'b1;
    bus.slave_result = 32'h0000_0042;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      check_output($sformatf("t2_grant_%0d", i), 72'(bus.grant), 72'(exp_grant[i]));
      check_output($sformatf("t2_fair_%0d", i), 72'(dut.fair_cnt), 72'(exp_fair[i]));
      next_cycle();
      check_output($sformatf("t2_idle_%0d", i), 72'(bus.grant), 72'(2'b00));
    end
    bus.a_cmd     = '0;
    bus.b_cmd     = '0;
    bus.slave_ack = 1'b0;

    // A write held in slave_cmd although A switches to a read mid-transaction
    wr_cmd = mk(1'b0, 1'b1, 30'h20, 4'b0011, 32'h1234_5678);
    next_cycle();
    bus.a_cmd = wr_cmd;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check_output($sformatf("t3_slave_cmd_%0d", i), 72'(bus.slave_cmd), 72'(wr_cmd));
      check_output($sformatf("t3_a_done_%0d", i), 72'(bus.a_done), 72'(0));
      bus.a_cmd = mk(1'b1, 1'b0, 30'h30, 4'hF, 32'h0);
    end
    next_cycle();
    bus.slave_ack = 1'b1;
    #1;
    check_output("t3_slave_cmd_3", 72'(bus.slave_cmd), 72'(wr_cmd));
    check_output("t3_a_done", 72'(bus.a_done), 72'(1));
    check_output("t3_a_err", 72'(bus.a_err), 72'(0));
    bus.a_cmd = '0;
    next_cycle();
    bus.slave_ack = 1'b0;
    #1;
    check_output("t3_after_grant", 72'(bus.grant), 72'(2'b00));
    check_output("t3_after_a_done", 72'(bus.a_done), 72'(0));

    // B read, slave never acks: timeout
    bus.b_cmd        = mk(1'b1, 1'b0, 30'h40, 4'hF, 32'h0);
    bus.slave_result = 32'hDEAD_BEEF;
    for (int k = 1; k <= 15; k++) begin
      next_cycle();
      check_output($sformatf("t4_b_done_%0d", k), 72'(bus.b_done), 72'(0));
    end
    next_cycle();
    check_output("t4_grant", 72'(bus.grant), 72'(2'b10));
    check_output("t4_b_done", 72'(bus.b_done), 72'(1));
    check_output("t4_b_err", 72'(bus.b_err), 72'(1));
    check_output("t4_b_result", 72'(bus.b_result), 72'(0));
    bus.b_cmd = '0;
    next_cycle();
    check_output("t4_grant_idle", 72'(bus.grant), 72'(2'b00));
    check_output("t4_slave_cmd_idle", 72'(bus.slave_cmd), 72'(0));
    next_cycle();
    bus.slave_ack = 1'b1;
    #1;
    check_output("t4_late_b_done", 72'(bus.b_done), 72'(0));
    check_output("t4_late_b_err", 72'(bus.b_err), 72'(0));
    check_output("t4_late_a_done", 72'(bus.a_done), 72'(0));
    next_cycle();
    bus.slave_ack = 1'b0;
    #1;
    check_output("t4_still_idle", 72'(bus.grant), 72'(2'b00));

    // Reset asserted mid-BUSY_A in the ack cycle
    bus.a_cmd = mk(1'b1, 1'b0, 30'h50, 4'hF, 32'h0);
    next_cycle();
    check_output("t5_grant_busy", 72'(bus.grant), 72'(2'b01));
    bus.slave_ack    = 1'b1;
    bus.slave_result = 32'h1111_2222;
    rst              = 1'b0;
    #1;
    check_output("t5_rst_grant", 72'(bus.grant), 72'(2'b00));
    check_output("t5_rst_a_done", 72'(bus.a_done), 72'(0));
    check_output("t5_rst_slave_cmd", 72'(bus.slave_cmd), 72'(0));
    check_output("t5_rst_a_result", 72'(bus.a_result), 72'(0));
    next_cycle();
    bus.slave_ack = 1'b0;
    rst           = 1'b1;
    #1;
    check_output("t5_rel_grant", 72'(bus.grant), 72'(2'b00));
    next_cycle();
    check_output("t5_regrant", 72'(bus.grant), 72'(2'b01));
    bus.slave_ack = 1'b1;
    #1;
    check_output("t5_a_done", 72'(bus.a_done), 72'(1));
    bus.a_cmd = '0;
    next_cycle();
    bus.slave_ack = 1'b0;

    // Ack arriving on the last allowed cycle is a normal completion
    bus.a_cmd        = mk(1'b1, 1'b0, 30'h60, 4'hF, 32'h0);
    bus.slave_result = 32'h5A5A_A5A5;
    for (int k = 1; k <= 15; k++) next_cycle();
    check_output("t6_a_done_before", 72'(bus.a_done), 72'(0));
    next_cycle();
    bus.slave_ack = 1'b1;
    #1;
    check_output("t6_a_done", 72'(bus.a_done), 72'(1));
    check_output("t6_a_err", 72'(bus.a_err), 72'(0));
    check_output("t6_a_result", 72'(bus.a_result), 72'(32'h5A5A_A5A5));
    bus.a_cmd = '0;
    next_cycle();
    bus.slave_ack = 1'b0;
    #1;
    check_output("t6_idle_grant", 72'(bus.grant), 72'(2'b00));
    check_output("t6_idle_a_done", 72'(bus.a_done), 72'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
